// File: rtl/insertion_sorter_nx.sv
// Streaming insertion sorter: loads a frame one element per cycle into a
// register array that is kept sorted, then drains it head-first.
module insertion_sorter_nx #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   input  logic             last_i,
   input  logic             descend_i,
   output logic             ready_o,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             last_o,
   input  logic             ready_i,
   output logic [CNT_W-1:0] count_o
);

   typedef enum logic {LOAD, DRAIN} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] mem     [DEPTH];
   logic [WIDTH-1:0] ins_mem [DEPTH];
   logic [CNT_W-1:0] count;
   logic             desc_q;
   logic             desc_eff;
   logic             accept;
   logic             pop;
   logic [DEPTH-1:0] keep;

   // State register
   always_ff @(posedge clk_i) begin
      if (reset_i) state <= LOAD;
      else         state <= state_nxt;
   end

   // Next-state, handshakes and output gating (everything forced low in reset)
   always_comb begin
      state_nxt = state;
      ready_o   = 1'b0;
      valid_o   = 1'b0;
      accept    = 1'b0;
      pop       = 1'b0;
      if (!reset_i) begin
         unique case (state)
            LOAD: begin
               ready_o = 1'b1;
               accept  = valid_i;
               if (accept && (last_i || count == CNT_W'(DEPTH - 1)))
                  state_nxt = DRAIN;
            end
            DRAIN: begin
               valid_o = 1'b1;
               pop     = ready_i;
               if (pop && count == CNT_W'(1))
                  state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
         endcase
      end
      data_o  = valid_o ? mem[0] : '0;
      last_o  = valid_o && (count == CNT_W'(1));
      count_o = reset_i ? '0 : count;
   end

   // Insertion network: keep[i] marks stored entries that stay ahead of the
   // new element. Because the array is sorted these form a prefix, so the
   // first non-kept slot takes data_i and later slots take their neighbour.
   always_comb begin
      desc_eff = (count == '0) ? descend_i : desc_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         keep[i] = (CNT_W'(i) < count) &&
                   (desc_eff ? (mem[i] >= data_i) : (mem[i] <= data_i));
      end
      ins_mem[0] = keep[0] ? mem[0] : data_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         if (keep[i])          ins_mem[i] = mem[i];
         else if (keep[i - 1]) ins_mem[i] = data_i;
         else                  ins_mem[i] = mem[i - 1];
      end
   end

   // Storage, occupancy and order flag
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         count  <= '0;
         desc_q <= 1'b0;
      end else if (accept) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= ins_mem[i];
         count <= count + CNT_W'(1);
         if (count == '0) desc_q <= descend_i;
      end else if (pop) begin
         for (int unsigned i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i + 1];
         mem[DEPTH-1] <= '0;
         count        <= count - CNT_W'(1);
      end
   end

endmodule
